// File: rtl/jump_branch_unit_pkg.sv
// Shared decode constants, RAS action encoding and the immediate sign extender
// used by the control-transfer unit.
package jump_branch_unit_pkg;

  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_POP_PUSH
  } ras_action_e;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_J,
    IMM_B
  } imm_kind_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

  // Immediates are at most 21 bits, so a 32-bit result is enough; callers widen further.
  function automatic logic [31:0] sext_imm(input logic [31:0] inst, input imm_kind_e kind);
    logic [31:0] imm;
    imm = '0;
    case (kind)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_J:   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_B:   imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/jump_branch_unit_ras.sv
// Circular return-address stack: pushing when full overwrites the oldest entry,
// and a simultaneous pop+push on a non-empty stack replaces the top in place.
module ras_stack
  import jump_branch_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   top_ptr;
  logic [PW-1:0]   top_ptr_inc;
  logic [CW-1:0]   count;
  logic            replace;
  logic            pop_only;

  assign empty       = (count == '0);
  assign top         = mem[top_ptr];
  assign top_ptr_inc = top_ptr + 1'b1;
  assign replace     = push && pop && !empty;
  assign pop_only    = pop && !push && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (replace) begin
      top_ptr <= top_ptr;
      count   <= count;
    end else if (push) begin
      top_ptr <= top_ptr_inc;
      count   <= (count == FULL) ? count : count + 1'b1;
    end else if (pop_only) begin
      top_ptr <= top_ptr - 1'b1;
      count   <= count - 1'b1;
    end
  end

  // Entry contents carry no reset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (replace) begin
        mem[top_ptr] <= push_data;
      end else if (push) begin
        mem[top_ptr_inc] <= push_data;
      end
    end
  end

endmodule

// File: rtl/jump_branch_unit.sv
// Single-stage resolver for JAL/JALR/branches with a return-address stack that
// predicts JALR returns; all results appear one cycle after the instruction.
module jump_branch_unit
  import jump_branch_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8,
  parameter int IALIGN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  output logic            is_cti,
  output logic            taken,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] link_addr,
  output logic            misaligned,
  output logic            illegal,
  output logic            ras_pred_valid,
  output logic [XLEN-1:0] ras_pred,
  output logic            ras_mispredict
);

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc_c;
  logic            is_cti_c;
  logic            taken_c;
  logic            illegal_c;
  logic            misaligned_c;
  ras_action_e     action;
  logic            fire;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            pred_valid_c;
  logic            mispredict_c;
  logic            br_eq;
  logic            br_lt;
  logic            br_ltu;

  assign opcode   = inst[6:0];
  assign rd       = inst[11:7];
  assign funct3   = inst[14:12];
  assign rs1      = inst[19:15];
  assign imm_i    = XLEN'($signed(sext_imm(inst, IMM_I)));
  assign imm_j    = XLEN'($signed(sext_imm(inst, IMM_J)));
  assign imm_b    = XLEN'($signed(sext_imm(inst, IMM_B)));
  assign pc_plus4 = pc + XLEN'(4);

  assign br_eq  = (rs1_data == rs2_data);
  assign br_lt  = ($signed(rs1_data) < $signed(rs2_data));
  assign br_ltu = (rs1_data < rs2_data);

  always_comb begin
    is_cti_c  = 1'b0;
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    target    = pc_plus4;
    action    = RAS_NONE;
    case (opcode)
      OPC_JAL: begin
        is_cti_c = 1'b1;
        taken_c  = 1'b1;
        target   = pc + imm_j;
        if (is_link(rd)) action = RAS_PUSH;
      end
      OPC_JALR: begin
        is_cti_c = 1'b1;
        taken_c  = 1'b1;
        target   = (rs1_data + imm_i) & ~XLEN'(1);
        // Return-hint table: rd link alone pushes, rs1 link alone pops,
        // both linked and distinct is a coroutine swap.
        case ({is_link(rd), is_link(rs1)})
          2'b10:   action = RAS_PUSH;
          2'b01:   action = RAS_POP;
          2'b11:   action = (rd == rs1) ? RAS_PUSH : RAS_POP_PUSH;
          default: action = RAS_NONE;
        endcase
      end
      OPC_BRANCH: begin
        is_cti_c = 1'b1;
        target   = pc + imm_b;
        case (funct3)
          F3_BEQ:  taken_c = br_eq;
          F3_BNE:  taken_c = !br_eq;
          F3_BLT:  taken_c = br_lt;
          F3_BGE:  taken_c = !br_lt;
          F3_BLTU: taken_c = br_ltu;
          F3_BGEU: taken_c = !br_ltu;
          default: illegal_c = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  assign next_pc_c    = taken_c ? target : pc_plus4;
  assign misaligned_c = (IALIGN == 32) && taken_c && target[1];

  assign fire     = in_valid && !flush && !rst;
  assign ras_push = fire && ((action == RAS_PUSH) || (action == RAS_POP_PUSH));
  assign ras_pop  = fire && ((action == RAS_POP) || (action == RAS_POP_PUSH));

  // Prediction is taken from the top before any same-cycle push lands.
  assign pred_valid_c = ras_pop && !ras_empty;
  assign mispredict_c = ras_pop && (ras_empty || (ras_top != target));

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      is_cti         <= 1'b0;
      taken          <= 1'b0;
      next_pc        <= '0;
      link_addr      <= '0;
      misaligned     <= 1'b0;
      illegal        <= 1'b0;
      ras_pred_valid <= 1'b0;
      ras_pred       <= '0;
      ras_mispredict <= 1'b0;
    end else begin
      out_valid      <= fire;
      is_cti         <= fire && is_cti_c;
      taken          <= fire && taken_c;
      next_pc        <= fire ? next_pc_c : '0;
      link_addr      <= fire ? pc_plus4 : '0;
      misaligned     <= fire && misaligned_c;
      illegal        <= fire && illegal_c;
      ras_pred_valid <= pred_valid_c;
      ras_pred       <= pred_valid_c ? ras_top : '0;
      ras_mispredict <= mispredict_c;
    end
  end

endmodule

// File: tb/tb_jump_branch_unit.sv
// Scoreboard bench for jump_branch_unit: IALIGN=32 and IALIGN=16 instances share
// stimulus; expected results are queued at issue and popped when out_valid shows.
module tb_jump_branch_unit;

  typedef struct packed {
    logic        is_cti;
    logic        taken;
    logic [31:0] next_pc;
    logic [31:0] link_addr;
    logic        misaligned;
    logic        illegal;
    logic        pred_valid;
    logic [31:0] pred;
    logic        mispredict;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush;
  logic [31:0] pc, inst, rs1_data, rs2_data;

  logic        v32, c32, t32, m32, i32, pv32, mp32;
  logic [31:0] npc32, la32, pr32;
  logic        v16, c16, t16, m16, i16, pv16, mp16;
  logic [31:0] npc16, la16, pr16;

  res_t q32[$];
  res_t q16[$];
  int   checks = 0;
  int   errors = 0;
  int   n32 = 0;
  int   n16 = 0;

  always #5 clk = ~clk;

  jump_branch_unit #(.XLEN(32), .RAS_DEPTH(8), .IALIGN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .pc(pc), .inst(inst),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(v32), .is_cti(c32), .taken(t32),
    .next_pc(npc32), .link_addr(la32), .misaligned(m32), .illegal(i32),
    .ras_pred_valid(pv32), .ras_pred(pr32), .ras_mispredict(mp32)
  );

  jump_branch_unit #(.XLEN(32), .RAS_DEPTH(8), .IALIGN(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .pc(pc), .inst(inst),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(v16), .is_cti(c16), .taken(t16),
    .next_pc(npc16), .link_addr(la16), .misaligned(m16), .illegal(i16),
    .ras_pred_valid(pv16), .ras_pred(pr16), .ras_mispredict(mp16)
  );

  function automatic res_t mk(input logic cti, tk, input logic [31:0] npc, la,
                              input logic mis, ill, pv, input logic [31:0] pr, input logic mp);
    res_t r;
    r = '{is_cti: cti, taken: tk, next_pc: npc, link_addr: la, misaligned: mis,
          illegal: ill, pred_valid: pv, pred: pr, mispredict: mp};
    return r;
  endfunction

  function automatic void report(input string name, input int idx, input res_t a, input res_t e);
    $display("FAIL %s rec%0d: got cti=%b tk=%b npc=%h link=%h mis=%b ill=%b pv=%b pred=%h mp=%b; required cti=%b tk=%b npc=%h link=%h mis=%b ill=%b pv=%b pred=%h mp=%b",
             name, idx, a.is_cti, a.taken, a.next_pc, a.link_addr, a.misaligned, a.illegal,
             a.pred_valid, a.pred, a.mispredict, e.is_cti, e.taken, e.next_pc, e.link_addr,
             e.misaligned, e.illegal, e.pred_valid, e.pred, e.mispredict);
  endfunction

  // Monitor: sample on the falling edge, away from the registered update.
  always @(negedge clk) begin
    res_t a, e;
    if (v32) begin
      checks++;
      a = mk(c32, t32, npc32, la32, m32, i32, pv32, pr32, mp32);
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL ialign32 unexpected out_valid: got 1 required 0 (rec%0d)", n32);
      end else begin
        e = q32.pop_front();
        if (a !== e) begin
          errors++;
          report("ialign32", n32, a, e);
        end
      end
      n32++;
    end
    if (v16) begin
      checks++;
      a = mk(c16, t16, npc16, la16, m16, i16, pv16, pr16, mp16);
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL ialign16 unexpected out_valid: got 1 required 0 (rec%0d)", n16);
      end else begin
        e = q16.pop_front();
        if (a !== e) begin
          errors++;
          report("ialign16", n16, a, e);
        end
      end
      n16++;
    end
  end

  task automatic drive(input logic [31:0] i_inst, i_pc, i_rs1, i_rs2, input logic r, f);
    @(negedge clk);
    rst      = r;
    flush    = f;
    in_valid = 1'b1;
    inst     = i_inst;
    pc       = i_pc;
    rs1_data = i_rs1;
    rs2_data = i_rs2;
  endtask

  task automatic issue(input logic [31:0] i_inst, i_pc, i_rs1, i_rs2, input res_t e);
    res_t e16;
    drive(i_inst, i_pc, i_rs1, i_rs2, 1'b0, 1'b0);
    q32.push_back(e);
    e16 = e;
    e16.misaligned = 1'b0;
    q16.push_back(e16);
  endtask

  localparam logic [31:0] JAL_X1_P100  = 32'h100000EF;
  localparam logic [31:0] JAL_X0_M16   = 32'hFF1FF06F;
  localparam logic [31:0] JALR_X0_X1   = 32'h00008067;
  localparam logic [31:0] JALR_X0_X5   = 32'h00028067;
  localparam logic [31:0] JALR_X0_X6   = 32'h00030067;
  localparam logic [31:0] JALR_X0_M4X6 = 32'hFFC30067;
  localparam logic [31:0] JALR_X5_X1   = 32'h000082E7;

  initial begin
    logic [31:0] lnk;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    pc = '0; inst = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({v32, c32, t32, npc32, la32, m32, i32, pv32, pr32, mp32} !== '0 ||
        {v16, c16, t16, npc16, la16, m16, i16, pv16, pr16, mp16} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b npc=%h link=%h required all zero", v32, npc32, la32);
    end
    @(negedge clk);
    rst = 1'b0;

    // Jumps and returns
    issue(JAL_X0_M16,  32'h1000, 0, 0, mk(1, 1, 32'h0FF0, 32'h1004, 0, 0, 0, 0, 0));
    issue(JAL_X0_M16,  32'h0008, 0, 0, mk(1, 1, 32'hFFFF_FFF8, 32'h000C, 0, 0, 0, 0, 0));
    issue(JAL_X1_P100, 32'h1000, 0, 0, mk(1, 1, 32'h1100, 32'h1004, 0, 0, 0, 0, 0));
    issue(JALR_X0_X1,  32'h1100, 32'h1004, 0, mk(1, 1, 32'h1004, 32'h1104, 0, 0, 1, 32'h1004, 0));
    issue(JALR_X0_X1,  32'h2000, 32'h0500, 0, mk(1, 1, 32'h0500, 32'h2004, 0, 0, 0, 0, 1));
    issue(JALR_X0_X6,  32'h1004, 32'h2003, 0, mk(1, 1, 32'h2002, 32'h1008, 1, 0, 0, 0, 0));
    issue(JALR_X0_M4X6, 32'h0050, 32'h1001, 0, mk(1, 1, 32'h0FFC, 32'h0054, 0, 0, 0, 0, 0));

    // Branches
    issue(32'h00314463, 32'h40, 32'hFFFF_FFFF, 1, mk(1, 1, 32'h48, 32'h44, 0, 0, 0, 0, 0));
    issue(32'h00316463, 32'h40, 32'hFFFF_FFFF, 1, mk(1, 0, 32'h44, 32'h44, 0, 0, 0, 0, 0));
    issue(32'h00312463, 32'h40, 32'hFFFF_FFFF, 1, mk(1, 0, 32'h44, 32'h44, 0, 1, 0, 0, 0));
    issue(32'h00310463, 32'h40, 5, 5, mk(1, 1, 32'h48, 32'h44, 0, 0, 0, 0, 0));
    issue(32'h00310363, 32'h40, 5, 5, mk(1, 1, 32'h46, 32'h44, 1, 0, 0, 0, 0));
    issue(32'h00311363, 32'h40, 5, 5, mk(1, 0, 32'h44, 32'h44, 0, 0, 0, 0, 0));
    issue(32'hFE311CE3, 32'h100, 1, 2, mk(1, 1, 32'hF8, 32'h104, 0, 0, 0, 0, 0));
    issue(32'hFE315CE3, 32'h100, 32'hFFFF_FFFF, 1, mk(1, 0, 32'h104, 32'h104, 0, 0, 0, 0, 0));
    issue(32'hFE317CE3, 32'h100, 32'hFFFF_FFFF, 1, mk(1, 1, 32'hF8, 32'h104, 0, 0, 0, 0, 0));
    issue(32'h00100093, 32'h300, 0, 0, mk(0, 0, 32'h304, 32'h304, 0, 0, 0, 0, 0));

    // Overfill the stack, then drain it past empty
    for (int k = 1; k <= 9; k++) begin
      lnk = 32'(k) << 4;
      issue(JAL_X1_P100, lnk - 32'h4, 0, 0, mk(1, 1, lnk + 32'hFC, lnk, 0, 0, 0, 0, 0));
    end
    for (int k = 9; k >= 2; k--) begin
      lnk = 32'(k) << 4;
      issue(JALR_X0_X1, 32'h400, lnk, 0, mk(1, 1, lnk, 32'h404, 0, 0, 1, lnk, 0));
    end
    issue(JALR_X0_X1, 32'h400, 32'h10, 0, mk(1, 1, 32'h10, 32'h404, 0, 0, 0, 0, 1));

    // Pop-then-push swap replaces the top without changing depth
    issue(JAL_X1_P100, 32'h600, 0, 0, mk(1, 1, 32'h700, 32'h604, 0, 0, 0, 0, 0));
    issue(JALR_X5_X1, 32'h700, 32'h704, 0, mk(1, 1, 32'h704, 32'h704, 0, 0, 1, 32'h604, 1));
    issue(JALR_X0_X5, 32'h704, 32'h704, 0, mk(1, 1, 32'h704, 32'h708, 0, 0, 1, 32'h704, 0));
    issue(JALR_X0_X1, 32'h708, 32'h20, 0, mk(1, 1, 32'h20, 32'h70C, 0, 0, 0, 0, 1));

    // Flush suppresses output and leaves the stack alone
    issue(JAL_X1_P100, 32'h900, 0, 0, mk(1, 1, 32'hA00, 32'h904, 0, 0, 0, 0, 0));
    drive(JAL_X1_P100, 32'hA00, 0, 0, 1'b0, 1'b1);
    issue(JALR_X0_X1, 32'hE00, 32'h904, 0, mk(1, 1, 32'h904, 32'hE04, 0, 0, 1, 32'h904, 0));
    issue(JALR_X0_X1, 32'hE00, 32'h0, 0, mk(1, 1, 32'h0, 32'hE04, 0, 0, 0, 0, 1));

    // Reset beats a same-cycle instruction and empties the stack
    issue(JAL_X1_P100, 32'hB00, 0, 0, mk(1, 1, 32'hC00, 32'hB04, 0, 0, 0, 0, 0));
    drive(JAL_X1_P100, 32'hD00, 0, 0, 1'b1, 1'b0);
    issue(JALR_X0_X1, 32'hF00, 32'hD04, 0, mk(1, 1, 32'hD04, 32'hF04, 0, 0, 0, 0, 1));

    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (q32.size() != 0 || q16.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d outstanding results required 0/0", q32.size(), q16.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
